uart_loader_ctrl: RTL and testbench

UART_LOADER_CTRL -- requirements
Module: uart_loader_ctrl

---
 rtl/loader_pkg.sv | 19 +
 rtl/uart_loader_ctrl.sv | 172 +++++++++++++++++
 tb/tb_uart_loader_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART memory loader.
package loader_pkg;

    // Loader control states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_SUM  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // Header word-count bytes, bytes per memory word, trailing checksum bytes.
    localparam int unsigned HDR_BYTES  = 4;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned SUM_BYTES  = 1;

endpackage

// File: rtl/uart_loader_ctrl.sv
// UART boot loader: header word count, big-endian data words written to
// memory, trailing 8-bit additive checksum, idle-gap watchdog.
module uart_loader_ctrl
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned GAP_MAX = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned GAP_W = $clog2(GAP_MAX + 1);
    localparam int unsigned IDX_W = ADDR_W + 1;
    // Capacity in words; one extra bit so 2**32 would still be representable.
    localparam logic [32:0] CAP   = 33'(1) << ADDR_W;

    state_t             state;
    state_t             state_nx;
    logic [1:0]         byte_cnt;
    logic [IDX_W-1:0]   word_idx;
    logic [31:0]        n_words;
    logic [23:0]        shreg;
    logic [7:0]         csum;
    logic [GAP_W-1:0]   gap_cnt;

    logic               active_c;
    logic               byte_c;
    logic               last_byte_c;
    logic               timeout_c;
    logic               write_c;
    logic               last_word_c;
    logic [31:0]        asm_word_c;

    logic               mem_we_nx;
    logic [ADDR_W-1:0]  mem_addr_nx;
    logic [31:0]        mem_wdata_nx;
    logic               busy_nx;
    logic               done_nx;
    logic               error_nx;

    // Shared decode of the current byte and counter conditions.
    always_comb begin
        active_c    = (state == ST_HDR) || (state == ST_DATA) || (state == ST_SUM);
        byte_c      = active_c && rx_valid && !rx_err;
        asm_word_c  = {shreg, rx_data};
        last_byte_c = (byte_cnt == 2'(WORD_BYTES - 1));
        timeout_c   = active_c && !rx_valid && (gap_cnt == GAP_W'(GAP_MAX - 1));
        write_c     = (state == ST_DATA) && byte_c && last_byte_c;
        last_word_c = ((32'(word_idx) + 32'd1) == n_words);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a framing error or idle timeout aborts any active phase.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_nx = ST_HDR;
                end
            end
            ST_HDR: begin
                if (rx_err || timeout_c) begin
                    state_nx = ST_ERR;
                end else if (byte_c && byte_cnt == 2'(HDR_BYTES - 1)) begin
                    if (asm_word_c == 32'd0) begin
                        state_nx = ST_SUM;
                    end else if ({1'b0, asm_word_c} > CAP) begin
                        state_nx = ST_ERR;
                    end else begin
                        state_nx = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_err || timeout_c) begin
                    state_nx = ST_ERR;
                end else if (write_c && last_word_c) begin
                    state_nx = ST_SUM;
                end
            end
            ST_SUM: begin
                if (rx_err || timeout_c) begin
                    state_nx = ST_ERR;
                end else if (byte_c && byte_cnt == 2'(SUM_BYTES - 1)) begin
                    state_nx = (rx_data == csum) ? ST_DONE : ST_ERR;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Byte assembler, word index, checksum and idle-gap counter.
    always_ff @(posedge clk) begin
        if (rst || (start && !active_c)) begin
            byte_cnt <= 2'd0;
            word_idx <= '0;
            n_words  <= 32'd0;
            shreg    <= 24'd0;
            csum     <= 8'd0;
            gap_cnt  <= '0;
        end else if (active_c) begin
            gap_cnt <= rx_valid ? '0 : gap_cnt + GAP_W'(1);
            if (byte_c) begin
                byte_cnt <= byte_cnt + 2'd1;
                shreg    <= asm_word_c[23:0];
                if (state == ST_HDR && last_byte_c) begin
                    n_words <= asm_word_c;
                end
                if (state == ST_DATA) begin
                    csum <= csum + rx_data;
                end
                if (write_c) begin
                    word_idx <= word_idx + IDX_W'(1);
                end
            end
        end
    end

    // Next values of the registered outputs; status flags track the state.
    always_comb begin
        mem_we_nx    = write_c;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        busy_nx      = active_c;
        done_nx      = (state == ST_DONE);
        error_nx     = (state == ST_ERR);
        if (write_c) begin
            mem_addr_nx  = word_idx[ADDR_W-1:0];
            mem_wdata_nx = asm_word_c;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            error     <= error_nx;
        end
    end

endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Directed bench for uart_loader_ctrl: vector table of whole loads plus
// hand-written sequences for timeout, rx_err, reset mid-load and full capacity.
module tb_uart_loader_ctrl;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned GAP_MAX = 100;
    localparam int unsigned WR_MAX  = 2048;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              error;

    int checks = 0;
    int errors = 0;

    // Write log filled by the monitor.
    int          wr_n = 0;
    logic [31:0] wr_addr [WR_MAX];
    logic [31:0] wr_data [WR_MAX];

    uart_loader_ctrl #(.ADDR_W(ADDR_W), .GAP_MAX(GAP_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_err    (rx_err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Capture memory writes away from the active edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr[wr_n % WR_MAX] = 32'(mem_addr);
            wr_data[wr_n % WR_MAX] = mem_wdata;
            wr_n = wr_n + 1;
        end
    end

    typedef struct {
        string       name;
        logic [31:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        int          nw;
        bit          has_sum;
        logic [7:0]  sum;
        logic        exp_done;
        int          exp_wr;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int          base;
        int          k;
        logic [7:0]  sum;
        logic [31:0] w;

        // 0x11+0x22+0x33+0x44+0xA0+0xB1+0xC2+0xD3 = 0x390 -> 0x90
        vecs[0] = '{"two_words_ok",  32'd2,     32'h11223344, 32'hA0B1C2D3, 2, 1'b1, 8'h90, 1'b1, 2};
        // 0x18 is not the byte sum of this payload, so the load must fail
        vecs[1] = '{"two_words_bad", 32'd2,     32'h11223344, 32'hA0B1C2D3, 2, 1'b1, 8'h18, 1'b0, 2};
        vecs[2] = '{"empty_ok",      32'd0,     32'h0,        32'h0,        0, 1'b1, 8'h00, 1'b1, 0};
        vecs[3] = '{"too_big",       32'h401,   32'h0,        32'h0,        0, 1'b0, 8'h00, 1'b0, 0};
        vecs[4] = '{"one_word_bad",  32'd1,     32'h01020304, 32'h0,        1, 1'b1, 8'h0B, 1'b0, 1};
        vecs[5] = '{"one_word_ok",   32'd1,     32'h01020304, 32'h0,        1, 1'b1, 8'h0A, 1'b1, 1};

        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_we",    32'(mem_we),    32'd0);
        chk("rst_mem_addr",  32'(mem_addr),  32'd0);
        chk("rst_mem_wdata", mem_wdata,      32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_error",     32'(error),     32'd0);
        rst = 1'b0;

        // Table of complete loads.
        for (int v = 0; v < 6; v++) begin
            base = wr_n;
            pulse_start();
            send_word(vecs[v].n);
            if (vecs[v].nw > 0) send_word(vecs[v].w0);
            if (vecs[v].nw > 1) send_word(vecs[v].w1);
            if (vecs[v].has_sum) send_byte(vecs[v].sum);
            settle();
            chk({vecs[v].name, "_done"},  32'(done),  32'(vecs[v].exp_done));
            chk({vecs[v].name, "_error"}, 32'(error), 32'(!vecs[v].exp_done));
            chk({vecs[v].name, "_busy"},  32'(busy),  32'd0);
            chk({vecs[v].name, "_wr_cnt"}, 32'(wr_n - base), 32'(vecs[v].exp_wr));
            for (int i = 0; i < vecs[v].exp_wr; i++) begin
                chk({vecs[v].name, "_wr_addr"}, wr_addr[(base + i) % WR_MAX], 32'(i));
                chk({vecs[v].name, "_wr_data"}, wr_data[(base + i) % WR_MAX],
                    (i == 0) ? vecs[v].w0 : vecs[v].w1);
            end
        end

        // Idle-gap watchdog: stall after two header bytes.
        base = wr_n;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        k = 0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (error) begin
                k = c;
                break;
            end
        end
        checks++;
        if (k < 100 || k > 101) begin
            errors++;
            $display("FAIL gap_timeout cycles=%0d required=100..101", k);
        end
        chk("gap_wr_cnt", 32'(wr_n - base), 32'd0);

        // Framing error during data: byte with rx_err is discarded, later bytes ignored.
        base = wr_n;
        pulse_start();
        send_word(32'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        @(negedge clk);
        rx_valid = 1'b1; rx_err = 1'b1; rx_data = 8'hDD;
        @(negedge clk);
        rx_valid = 1'b0; rx_err = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        settle();
        chk("rxerr_error",  32'(error), 32'd1);
        chk("rxerr_done",   32'(done),  32'd0);
        chk("rxerr_wr_cnt", 32'(wr_n - base), 32'd0);

        // Reset after five data bytes, then a clean one-word load.
        pulse_start();
        send_word(32'd2);
        send_word(32'h55667788);
        send_byte(8'h99);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy",  32'(busy),  32'd0);
        chk("midrst_we",    32'(mem_we), 32'd0);
        base = wr_n;
        send_byte(8'h12);
        settle();
        chk("midrst_no_wr", 32'(wr_n - base), 32'd0);
        chk("midrst_idle_done", 32'(done), 32'd0);
        pulse_start();
        send_word(32'd1);
        send_word(32'hCAFEF00D);
        // 0xCA+0xFE+0xF0+0x0D = 0x2C5 -> 0xC5
        send_byte(8'hC5);
        settle();
        chk("reload_done",    32'(done),  32'd1);
        chk("reload_error",   32'(error), 32'd0);
        chk("reload_wr_cnt",  32'(wr_n - base), 32'd1);
        chk("reload_wr_addr", wr_addr[base % WR_MAX], 32'd0);
        chk("reload_wr_data", wr_data[base % WR_MAX], 32'hCAFEF00D);

        // Full capacity: 1024 words, word i = {i, ~i}; start mid-load must be ignored.
        base = wr_n;
        sum  = 8'h00;
        pulse_start();
        send_word(32'h400);
        for (int i = 0; i < 1024; i++) begin
            w = {16'(i), ~16'(i)};
            sum = sum + w[31:24] + w[23:16] + w[15:8] + w[7:0];
            send_word(w);
            if (i == 100) begin
                chk("full_busy", 32'(busy), 32'd1);
                pulse_start();
            end
        end
        send_byte(sum);
        settle();
        chk("full_done",    32'(done),  32'd1);
        chk("full_error",   32'(error), 32'd0);
        chk("full_wr_cnt",  32'(wr_n - base), 32'd1024);
        chk("full_first_addr", wr_addr[base % WR_MAX], 32'd0);
        chk("full_last_addr",  wr_addr[(base + 1023) % WR_MAX], 32'd1023);
        chk("full_last_data",  wr_data[(base + 1023) % WR_MAX], {16'd1023, ~16'd1023});
        chk("full_hold_addr",  32'(mem_addr), 32'd1023);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
